// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the two buses of the instruction-memory loader:
//   - byte stream in : in_valid, in_data (source -> loader), in_ready (loader -> source)
//   - word write out : wr_en, wr_addr, wr_data (loader -> instruction memory)
// Modports:
//   master : the loader itself (consumes the stream, drives the write port)
//   slave  : the environment (byte source plus instruction memory)
// -----------------------------------------------------------------------------
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Writer side of the instruction memory. Receives a byte stream of the form
//   LEN_HI LEN_LO { b0 b1 b2 b3 } * LEN  CHK
// packs each group of four little-endian bytes into a 32-bit instruction and
// issues a single-cycle word write. The CPU is held in reset (cpu_hold) for the
// whole load. The load ends in DONE when the 8-bit sum of every accepted byte
// (length and check byte included) is zero, otherwise in ERR. A length larger
// than the space above BASE_ADDR goes straight to ERR without any write.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   one-cycle pulse, starts a load from IDLE, DONE or ERR
//   bus        master modport of imem_loader_if (byte stream in, word write out)
//   cpu_hold   out  high while a load is in progress
//   done       out  sticky, load finished with a good checksum
//   error      out  sticky, length too large or checksum mismatch
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [31:0] BASE      = 32'(BASE_ADDR);
    localparam logic [31:0] MAX_COUNT = 32'(DEPTH - BASE_ADDR);

    state_t      state;
    logic [15:0] count;      // length high byte while in LEN_LO, remaining words after
    logic [1:0]  byte_idx;   // position of the next data byte inside the word
    logic [23:0] word;       // lower three bytes; the fourth goes straight to wr_data
    logic [7:0]  chk;        // running sum of accepted bytes

    logic        xfer;
    logic [15:0] len_full;
    logic [7:0]  chk_sum;
    logic [15:0] count_dec;
    logic        len_too_big;

    always_comb begin
        // NOTE: every output of this block is assigned on every evaluation, so it
        // stays purely combinational; a path that skipped one would infer a latch.
        xfer        = bus.in_valid & bus.in_ready;
        len_full    = {count[15:8], bus.in_data};
        chk_sum     = chk + bus.in_data;
        count_dec   = count - 16'd1;
        len_too_big = ({16'd0, len_full} > MAX_COUNT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: all state here is updated with non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            state        <= IDLE;
            count        <= '0;
            byte_idx     <= '0;
            word         <= '0;
            chk          <= '0;
            bus.in_ready <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= BASE;
            bus.wr_data  <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse, raised only on the 4th data byte.
            bus.wr_en <= 1'b0;

            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= LEN_HI;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        cpu_hold     <= 1'b1;
                        bus.in_ready <= 1'b1;
                        bus.wr_addr  <= BASE;
                        count        <= '0;
                        byte_idx     <= '0;
                        word         <= '0;
                        chk          <= '0;
                    end
                end

                LEN_HI: begin
                    if (xfer) begin
                        count[15:8] <= bus.in_data;
                        chk         <= chk_sum;
                        state       <= LEN_LO;
                    end
                end

                LEN_LO: begin
                    // The full length is judged in the same cycle the low byte lands.
                    if (xfer) begin
                        count <= len_full;
                        chk   <= chk_sum;
                        if (len_too_big) begin
                            state        <= ERR;
                            error        <= 1'b1;
                            cpu_hold     <= 1'b0;
                            bus.in_ready <= 1'b0;
                        end else if (len_full == 16'd0) begin
                            state <= CHK;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (xfer) begin
                        chk      <= chk_sum;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word[7:0]   <= bus.in_data;
                            2'd1: word[15:8]  <= bus.in_data;
                            2'd2: word[23:16] <= bus.in_data;
                            default: begin
                                // Last byte: present the write next cycle and pause the stream.
                                state        <= WRITE;
                                bus.wr_en    <= 1'b1;
                                bus.wr_data  <= {bus.in_data, word};
                                bus.in_ready <= 1'b0;
                            end
                        endcase
                    end
                end

                WRITE: begin
                    // Write is on the bus this cycle; advance the address behind it.
                    bus.wr_addr  <= bus.wr_addr + 32'd1;
                    count        <= count_dec;
                    bus.in_ready <= 1'b1;
                    state        <= (count_dec == 16'd0) ? CHK : DATA;
                end

                CHK: begin
                    if (xfer) begin
                        bus.in_ready <= 1'b0;
                        cpu_hold     <= 1'b0;
                        chk          <= chk_sum;
                        if (chk_sum == 8'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end

                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b0;
                    cpu_hold     <= 1'b0;
                end
            endcase
        end
    end

endmodule
